// File: rtl/fifo_burst_drainer.sv
// ============================================================================
// fifo_burst_drainer : pops a FWFT FIFO and emits valid/ready bursts with last
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_burst_drainer #(
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_almost_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rden_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int c_BEATS_W = $clog2(BURST_LEN + 1);
  localparam int c_TCNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_BEATS_W-1:0] c_FULL_BEATS = c_BEATS_W'(BURST_LEN);
  localparam logic [c_BEATS_W-1:0] c_ONE_BEAT   = c_BEATS_W'(1);
  localparam logic [c_TCNT_W-1:0]  c_TCNT_LAST  = c_TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                  state_q,      state_d;
  logic [c_BEATS_W-1:0]    beats_left_q, beats_left_d;
  logic [c_TCNT_W-1:0]     tcnt_q,       tcnt_d;
  logic                    valid_q,      valid_d;
  logic [DATA_WIDTH-1:0]   data_q,       data_d;
  logic                    last_q,       last_d;
  logic                    w_pop;

  // A pop needs a free (or freeing) output slot, so backpressure never drops a beat.
  assign w_pop = (state_q == BURST) && !fifo_empty_i && (beats_left_q != '0) &&
                 (!valid_q || out_ready_i);

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    tcnt_d       = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_almost_empty_i) begin
          state_d      = BURST;
          beats_left_d = c_FULL_BEATS;
          tcnt_d       = '0;
        end else if (!fifo_empty_i && (tcnt_q == c_TCNT_LAST)) begin
          state_d      = BURST;
          beats_left_d = c_ONE_BEAT;
          tcnt_d       = '0;
        end else if (!fifo_empty_i) begin
          tcnt_d = tcnt_q + 1'b1;
        end else begin
          tcnt_d = '0;
        end
      end
      BURST: begin
        tcnt_d = '0;
        if (w_pop) begin
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == c_ONE_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (w_pop) begin
      valid_d = 1'b1;
      data_d  = fifo_rdata_i;
      last_d  = (beats_left_q == c_ONE_BEAT);
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      tcnt_q       <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      tcnt_q       <= tcnt_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      last_q       <= last_d;
    end
  end

  assign fifo_rden_o = w_pop;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_drainer.sv
// ============================================================================
// tb_fifo_burst_drainer : FIFO model + scoreboard bench for fifo_burst_drainer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_burst_drainer;

  localparam int DW       = 32;
  localparam int BL       = 4;
  localparam int TO       = 8;
  localparam int DEPTH    = 16;
  localparam int AE_LEVEL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          out_ready = 1'b0;

  logic          fifo_empty, fifo_ae, fifo_rden;
  logic [DW-1:0] fifo_rdata;
  logic          out_valid, out_last, busy;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  fifo_burst_drainer #(
    .DATA_WIDTH    (DW),
    .BURST_LEN     (BL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fifo_empty_i       (fifo_empty),
    .fifo_almost_empty_i(fifo_ae),
    .fifo_rdata_i       (fifo_rdata),
    .fifo_rden_o        (fifo_rden),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_data_o         (out_data),
    .out_last_o         (out_last),
    .busy_o             (busy)
  );

  // Behavioural first-word-fall-through FIFO sharing rst_n with the drainer.
  logic [DW-1:0] mem [DEPTH];
  int            wr_ptr, rd_ptr, count;

  always @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
      count  <= 0;
    end else begin
      if (wr_en && count < DEPTH) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr + 1) % DEPTH;
      end
      if (fifo_rden && count != 0) rd_ptr <= (rd_ptr + 1) % DEPTH;
      count <= count + ((wr_en && count < DEPTH) ? 1 : 0) - ((fifo_rden && count != 0) ? 1 : 0);
    end
  end

  assign fifo_empty = (count == 0);
  assign fifo_ae    = (count <= AE_LEVEL);
  assign fifo_rdata = mem[rd_ptr];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  beat_t         e_beat;
  int            checks = 0;
  int            failures = 0;
  int            tot_beats = 0;
  int            tot_lasts = 0;
  int            burst_rem = 0;
  int            idle_count = 0;
  bit            idle_seen = 1'b1;
  bit            held = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;
  int            cyc = 0;
  int            rdy_mode = 0;
  int            rdy_pct = 100;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Monitor: checks the output stream against the queue, and predicts the beats
  // each pop will produce. A burst is full-length when the FIFO held more than
  // the almost-empty level in the last IDLE cycle, otherwise it is a timeout single.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      burst_rem = 0;
      held      = 1'b0;
      idle_seen = 1'b1;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(held_data));
        chk("hold_last", 64'(out_last), 64'(held_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0d with nothing expected", out_data, out_last);
        end else begin
          e_beat = sb.pop_front();
          chk("beat_data", 64'(out_data), 64'(e_beat.data));
          chk("beat_last", 64'(out_last), 64'(e_beat.last));
        end
        tot_beats++;
        if (out_last) tot_lasts++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;

      if (fifo_empty) chk("rden_while_empty", 64'(fifo_rden), 64'd0);
      if (!busy) begin
        idle_count = count;
        idle_seen  = 1'b1;
        chk("rden_in_idle", 64'(fifo_rden), 64'd0);
      end
      if (fifo_rden && !fifo_empty) begin
        if (burst_rem == 0) begin
          chk("idle_gap_before_burst", 64'(idle_seen), 64'd1);
          burst_rem = (idle_count > AE_LEVEL) ? BL : 1;
          idle_seen = 1'b0;
        end
        sb.push_back(beat_t'({fifo_rdata, (burst_rem == 1)}));
        burst_rem--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rdy_mode == 1)      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    else if (rdy_mode == 2) out_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic write_seq(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + DW'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(count == 0 && sb.size() == 0 && !out_valid && !busy) && n < 300) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 64'(n < 300), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "global timeout");
  end

  initial begin
    int b0, l0, k, wp;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_rden", 64'(fifo_rden), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();

    // Two back-to-back full bursts
    b0 = tot_beats; l0 = tot_lasts;
    write_seq(32'h10, 8);
    wait_drain("t1");
    chk("t1_beats", 64'(tot_beats - b0), 64'd8);
    chk("t1_lasts", 64'(tot_lasts - l0), 64'd2);

    // Full burst under a 1,0,0,1 ready pattern
    b0 = tot_beats; l0 = tot_lasts;
    rdy_mode = 1;
    write_seq(32'hA0, 4);
    wait_drain("t2");
    chk("t2_beats", 64'(tot_beats - b0), 64'd4);
    chk("t2_lasts", 64'(tot_lasts - l0), 64'd1);
    rdy_mode  = 0;
    out_ready = 1'b1;
    repeat (3) step();

    // Single entry drained by the timeout
    b0 = tot_beats; l0 = tot_lasts;
    wr_en = 1'b1; wr_data = 32'h55;
    step();
    wr_en = 1'b0;
    k = 0;
    while (!fifo_rden && k < 40) begin
      step();
      k++;
    end
    chk("t3_timeout_latency", 64'(k), 64'(TO));
    wait_drain("t3");
    chk("t3_beats", 64'(tot_beats - b0), 64'd1);
    chk("t3_lasts", 64'(tot_lasts - l0), 64'd1);

    // Full burst, then a late entry that must leave via the timeout
    b0 = tot_beats; l0 = tot_lasts;
    write_seq(32'h01, 4);
    k = 0;
    while (!busy && k < 40) begin
      step();
      k++;
    end
    chk("t4_burst_started", 64'(busy), 64'd1);
    wr_en = 1'b1; wr_data = 32'h05;
    step();
    wr_en = 1'b0;
    wait_drain("t4");
    chk("t4_beats", 64'(tot_beats - b0), 64'd5);
    chk("t4_lasts", 64'(tot_lasts - l0), 64'd2);

    // Reset in the middle of a burst
    b0 = tot_beats; l0 = tot_lasts;
    write_seq(32'h30, 4);
    k = 0;
    while ((tot_beats - b0) < 2 && k < 40) begin
      step();
      k++;
    end
    chk("t5_two_beats_before_reset", 64'(tot_beats - b0), 64'd2);
    rst_n = 1'b0;
    step();
    chk("t5_valid_after_reset", 64'(out_valid), 64'd0);
    chk("t5_busy_after_reset", 64'(busy), 64'd0);
    chk("t5_last_after_reset", 64'(out_last), 64'd0);
    chk("t5_rden_after_reset", 64'(fifo_rden), 64'd0);
    rst_n = 1'b1;
    b0 = tot_beats;
    repeat (20) step();
    chk("t5_no_beats_after_reset", 64'(tot_beats - b0), 64'd0);
    chk("t5_no_last_emitted", 64'(tot_lasts - l0), 64'd0);
    chk("t5_still_idle", 64'(busy), 64'd0);

    // Random traffic and backpressure in phases of varying write and ready rates
    b0 = tot_beats; l0 = tot_lasts;
    rdy_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      case ((i / 1000) % 4)
        0:       begin wp = 3;  rdy_pct = 100; end
        1:       begin wp = 25; rdy_pct = 60;  end
        2:       begin wp = 60; rdy_pct = 25;  end
        default: begin wp = 90; rdy_pct = 80;  end
      endcase
      wr_en   = (count < DEPTH - 2) && ($urandom_range(0, 99) < wp);
      wr_data = $urandom;
      step();
    end
    wr_en     = 1'b0;
    rdy_mode  = 0;
    out_ready = 1'b1;
    wait_drain("t6");
    chk("t6_scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("t6_saw_traffic", 64'((tot_beats - b0) > 100), 64'd1);
    chk("t6_saw_lasts", 64'((tot_lasts - l0) > 10), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
